// File: rtl/pwm_dt_pkg.sv
// Shared definitions for the complementary dead-time generator.
// Holds the per-channel FSM state encoding, the register offsets inside a
// channel's 16-byte window and the bit positions inside the CTRL register.
package pwm_dt_pkg;

    // Encodings are visible to software through STATUS[2:0].
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HIGH   = 3'd1,
        ST_LOW    = 3'd2,
        ST_DEAD_H = 3'd3,
        ST_DEAD_L = 3'd4
    } dt_state_e;

    localparam logic [3:0] REG_CTRL   = 4'h0;
    localparam logic [3:0] REG_DT     = 4'h4;
    localparam logic [3:0] REG_STATUS = 4'h8;

    localparam int unsigned CTRL_EN    = 0;
    localparam int unsigned CTRL_INV_H = 1;
    localparam int unsigned CTRL_INV_L = 2;
    localparam int unsigned CTRL_W     = 3;

endpackage

// File: rtl/pwm_dt_channel.sv
// One dead-time channel: input register, FSM, dead-time counter, output flops.
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   en              CTRL.EN for this channel
//   inv_h, inv_l    output inversion for the high/low side
//   dt              dead-time length in clocks
//   pwm_in          raw PWM waveform bit
//   pwm_ena         PWM block channel enable
//   out_h, out_l    registered high-side/low-side drive
//   state_code      current FSM state (for STATUS)
//   pwm_q           registered copy of pwm_in (for STATUS)
module pwm_dt_channel
    import pwm_dt_pkg::*;
#(
    parameter int unsigned DT_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                inv_h,
    input  logic                inv_l,
    input  logic [DT_WIDTH-1:0] dt,
    input  logic                pwm_in,
    input  logic                pwm_ena,
    output logic                out_h,
    output logic                out_l,
    output logic [2:0]          state_code,
    output logic                pwm_q
);

    dt_state_e           state;
    dt_state_e           next_state;
    logic [DT_WIDTH-1:0] cnt;
    logic [DT_WIDTH-1:0] next_cnt;
    logic                next_h;
    logic                next_l;

    // State register, counter and input flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            pwm_q <= 1'b0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            pwm_q <= pwm_in;
        end
    end

    // Next-state logic. A dead period of N clocks is N cycles spent in a
    // DEAD_* state, with cnt running N-1 down to 0.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        if (!(en && pwm_ena)) begin
            next_state = ST_IDLE;
            next_cnt   = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (dt == '0) begin
                        next_state = pwm_q ? ST_HIGH : ST_LOW;
                    end else begin
                        next_state = pwm_q ? ST_DEAD_H : ST_DEAD_L;
                        next_cnt   = dt - DT_WIDTH'(1);
                    end
                end
                ST_HIGH: begin
                    if (!pwm_q) begin
                        if (dt == '0) begin
                            next_state = ST_LOW;
                        end else begin
                            next_state = ST_DEAD_L;
                            next_cnt   = dt - DT_WIDTH'(1);
                        end
                    end
                end
                ST_LOW: begin
                    if (pwm_q) begin
                        if (dt == '0) begin
                            next_state = ST_HIGH;
                        end else begin
                            next_state = ST_DEAD_H;
                            next_cnt   = dt - DT_WIDTH'(1);
                        end
                    end
                end
                // A pulse shorter than the dead time aborts the dead period
                // and falls straight back to the side that was on.
                ST_DEAD_H: begin
                    if (!pwm_q) begin
                        next_state = ST_LOW;
                    end else if (cnt == '0) begin
                        next_state = ST_HIGH;
                    end else begin
                        next_cnt = cnt - DT_WIDTH'(1);
                    end
                end
                ST_DEAD_L: begin
                    if (pwm_q) begin
                        next_state = ST_HIGH;
                    end else if (cnt == '0) begin
                        next_state = ST_LOW;
                    end else begin
                        next_cnt = cnt - DT_WIDTH'(1);
                    end
                end
                default: begin
                    next_state = ST_IDLE;
                    next_cnt   = '0;
                end
            endcase
        end
    end

    // Output decode from the next state so the output flops change on the
    // same edge as the state register.
    always_comb begin
        next_h = (next_state == ST_HIGH) ^ inv_h;
        next_l = (next_state == ST_LOW)  ^ inv_l;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_h <= 1'b0;
            out_l <= 1'b0;
        end else begin
            out_h <= next_h;
            out_l <= next_l;
        end
    end

    assign state_code = state;

endmodule

// File: rtl/pwm_deadtime.sv
// Complementary-output dead-time generator with a memory-mapped register page.
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   mem_addr        bus address, page decoded on [31:8], channel [7:4], reg [3:0]
//   mem_wdata       bus write data
//   mem_we, mem_re  single-cycle write strobe, read strobe
//   mem_rdata       combinational read data, 0 when not addressed
//   pwm_in, pwm_ena PWM waveform and enable, one bit per channel
//   out_h, out_l    high-side / low-side drive, one bit per channel
module pwm_deadtime
    import pwm_dt_pkg::*;
#(
    parameter logic [31:0] DT_BASE_ADDR = 32'h4000_3100,
    parameter int unsigned PWM_NUM      = 2,
    parameter int unsigned DT_WIDTH     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        mem_addr,
    input  logic [31:0]        mem_wdata,
    input  logic               mem_we,
    input  logic               mem_re,
    output logic [31:0]        mem_rdata,
    input  logic [PWM_NUM-1:0] pwm_in,
    input  logic [PWM_NUM-1:0] pwm_ena,
    output logic [PWM_NUM-1:0] out_h,
    output logic [PWM_NUM-1:0] out_l
);

    logic [CTRL_W-1:0]   ctrl   [PWM_NUM];
    logic [DT_WIDTH-1:0] dt_reg [PWM_NUM];
    logic [2:0]          state_code [PWM_NUM];
    logic [PWM_NUM-1:0]  pwm_q;

    logic        page_hit;
    logic [31:0] ch_idx;
    logic [3:0]  reg_sel;
    logic        unused_wdata;

    assign page_hit     = (mem_addr[31:8] == DT_BASE_ADDR[31:8]);
    assign ch_idx       = {28'd0, mem_addr[7:4]};
    assign reg_sel      = mem_addr[3:0];
    assign unused_wdata = ^mem_wdata;

    // Channel numbers at or above PWM_NUM never match the loop index, so
    // such writes fall through and reads stay 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < PWM_NUM; i++) begin
                ctrl[i]   <= '0;
                dt_reg[i] <= '0;
            end
        end else if (mem_we && page_hit) begin
            for (int unsigned i = 0; i < PWM_NUM; i++) begin
                if (ch_idx == i) begin
                    if (reg_sel == REG_CTRL) ctrl[i]   <= mem_wdata[CTRL_W-1:0];
                    if (reg_sel == REG_DT)   dt_reg[i] <= mem_wdata[DT_WIDTH-1:0];
                end
            end
        end
    end

    always_comb begin
        mem_rdata = '0;
        if (mem_re && page_hit) begin
            for (int unsigned i = 0; i < PWM_NUM; i++) begin
                if (ch_idx == i) begin
                    case (reg_sel)
                        REG_CTRL:   mem_rdata[CTRL_W-1:0]   = ctrl[i];
                        REG_DT:     mem_rdata[DT_WIDTH-1:0] = dt_reg[i];
                        REG_STATUS: mem_rdata[3:0]          = {pwm_q[i], state_code[i]};
                        default:    mem_rdata               = '0;
                    endcase
                end
            end
        end
    end

    for (genvar g = 0; g < PWM_NUM; g++) begin : g_ch
        pwm_dt_channel #(
            .DT_WIDTH (DT_WIDTH)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .en         (ctrl[g][CTRL_EN]),
            .inv_h      (ctrl[g][CTRL_INV_H]),
            .inv_l      (ctrl[g][CTRL_INV_L]),
            .dt         (dt_reg[g]),
            .pwm_in     (pwm_in[g]),
            .pwm_ena    (pwm_ena[g]),
            .out_h      (out_h[g]),
            .out_l      (out_l[g]),
            .state_code (state_code[g]),
            .pwm_q      (pwm_q[g])
        );
    end

endmodule

// File: tb/tb_pwm_deadtime.sv
module tb_pwm_deadtime;

    localparam logic [31:0] BASE = 32'h4000_3100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic [1:0]  pwm_in;
    logic [1:0]  pwm_ena;
    logic [1:0]  out_h;
    logic [1:0]  out_l;

    int checks   = 0;
    int failures = 0;

    pwm_deadtime #(
        .DT_BASE_ADDR (BASE),
        .PWM_NUM      (2),
        .DT_WIDTH     (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .pwm_in    (pwm_in),
        .pwm_ena   (pwm_ena),
        .out_h     (out_h),
        .out_l     (out_l)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ra(input int ch, input int off);
        return BASE + 32'(ch * 16 + off);
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        mem_addr  = addr;
        mem_wdata = data;
        mem_we    = 1'b1;
        @(negedge clk);
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        mem_addr = addr;
        mem_re   = 1'b1;
        #1;
        data     = mem_rdata;
        mem_re   = 1'b0;
        mem_addr = '0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        rst_n = 1'b0;
        repeat (3) step();
        checks++;
        if (out_h !== 2'b00 || out_l !== 2'b00) begin
            failures++;
            $display("FAIL reset_outs: out_h=%b out_l=%b expected 00/00", out_h, out_l);
        end
        rst_n = 1'b1;
        step();
        for (int ch = 0; ch < 2; ch++) begin
            for (int off = 0; off < 16; off += 4) begin
                bus_read(ra(ch, off), rd);
                checks++;
                if (rd !== 32'h0) begin
                    failures++;
                    $display("FAIL reset_reg ch%0d off%0h: got %h expected 0", ch, off, rd);
                end
            end
        end
        step();
    endtask

    // DT=4, 20-clock high pulse: latency 2, 4 dead clocks per edge, 16 high clocks.
    task automatic test_deadtime();
        logic [31:0] rd;
        int          nh;
        logic        exp_h, exp_l;
        pwm_in  = 2'b00;
        pwm_ena = 2'b11;
        bus_write(ra(0, 4), 32'd4);
        bus_write(ra(0, 0), 32'd1);
        repeat (10) step();
        bus_read(ra(0, 8), rd);
        checks++;
        if (rd !== 32'h2) begin
            failures++;
            $display("FAIL dt4_status_low: got %h expected 2", rd);
        end
        bus_read(ra(0, 4), rd);
        checks++;
        if (rd !== 32'h4) begin
            failures++;
            $display("FAIL dt4_readback: got %h expected 4", rd);
        end
        nh = 0;
        for (int i = 0; i < 40; i++) begin
            pwm_in[0] = (i < 20);
            step();
            exp_h = (i + 1 >= 6) && (i + 1 <= 21);
            exp_l = (i + 1 <= 1) || (i + 1 >= 26);
            if (out_h[0]) nh++;
            checks++;
            if (out_h[0] !== exp_h || out_l[0] !== exp_l) begin
                failures++;
                $display("FAIL dt4_wave k=%0d: h=%b l=%b expected h=%b l=%b",
                         i + 1, out_h[0], out_l[0], exp_h, exp_l);
            end
        end
        checks++;
        if (nh != 16) begin
            failures++;
            $display("FAIL dt4_high_len: got %0d expected 16", nh);
        end
        checks++;
        if (out_h[1] !== 1'b0 || out_l[1] !== 1'b0) begin
            failures++;
            $display("FAIL ch1_idle: h=%b l=%b expected 0/0", out_h[1], out_l[1]);
        end
    endtask

    task automatic test_dt0();
        logic exp_h, exp_l;
        bus_write(ra(0, 4), 32'd0);
        for (int i = 0; i < 10; i++) begin
            pwm_in[0] = (i < 4);
            step();
            exp_h = (i + 1 >= 2) && (i + 1 <= 5);
            exp_l = (i + 1 <= 1) || (i + 1 >= 6);
            checks++;
            if (out_h[0] !== exp_h || out_l[0] !== exp_l) begin
                failures++;
                $display("FAIL dt0_wave k=%0d: h=%b l=%b expected h=%b l=%b",
                         i + 1, out_h[0], out_l[0], exp_h, exp_l);
            end
        end
    endtask

    // 3-clock pulse against DT=8: dead period aborted, out_h never rises.
    task automatic test_glitch();
        logic exp_l;
        bus_write(ra(0, 4), 32'd8);
        for (int i = 0; i < 15; i++) begin
            pwm_in[0] = (i < 3);
            step();
            exp_l = (i + 1 <= 1) || (i + 1 >= 5);
            checks++;
            if (out_h[0] !== 1'b0 || out_l[0] !== exp_l) begin
                failures++;
                $display("FAIL glitch_wave k=%0d: h=%b l=%b expected h=0 l=%b",
                         i + 1, out_h[0], out_l[0], exp_l);
            end
        end
    endtask

    task automatic test_disable();
        logic [31:0] rd;
        bus_write(ra(0, 4), 32'd0);
        pwm_in[0] = 1'b1;
        repeat (3) step();
        checks++;
        if (out_h[0] !== 1'b1 || out_l[0] !== 1'b0) begin
            failures++;
            $display("FAIL dis_pre_high: h=%b l=%b expected 1/0", out_h[0], out_l[0]);
        end
        pwm_ena[0] = 1'b0;
        step();
        checks++;
        if (out_h[0] !== 1'b0 || out_l[0] !== 1'b0) begin
            failures++;
            $display("FAIL dis_outs: h=%b l=%b expected 0/0", out_h[0], out_l[0]);
        end
        bus_read(ra(0, 8), rd);
        checks++;
        if (rd !== 32'h8) begin
            failures++;
            $display("FAIL dis_status: got %h expected 8", rd);
        end
        bus_write(ra(0, 0), 32'h5);
        step();
        checks++;
        if (out_h[0] !== 1'b0 || out_l[0] !== 1'b1) begin
            failures++;
            $display("FAIL inv_l_idle: h=%b l=%b expected 0/1", out_h[0], out_l[0]);
        end
        bus_write(ra(0, 0), 32'h1);
        step();
        checks++;
        if (out_l[0] !== 1'b0) begin
            failures++;
            $display("FAIL inv_l_clear: l=%b expected 0", out_l[0]);
        end
    endtask

    // DT rewritten from 10 to 2 inside a dead period.
    task automatic test_dt_rewrite();
        logic [31:0] rd;
        logic        exp_h, exp_l;
        bus_write(ra(0, 4), 32'd10);
        pwm_ena = 2'b11;
        repeat (15) step();
        checks++;
        if (out_h[0] !== 1'b1) begin
            failures++;
            $display("FAIL rw_pre_high: h=%b expected 1", out_h[0]);
        end
        for (int i = 0; i < 25; i++) begin
            pwm_in[0] = (i >= 15);
            if (i == 3) begin
                mem_addr  = ra(0, 4);
                mem_wdata = 32'd2;
                mem_we    = 1'b1;
            end else if (i == 4) begin
                mem_we    = 1'b0;
                mem_addr  = '0;
                mem_wdata = '0;
            end
            step();
            exp_h = (i + 1 <= 1) || (i + 1 >= 19);
            exp_l = (i + 1 >= 12) && (i + 1 <= 16);
            checks++;
            if (out_h[0] !== exp_h || out_l[0] !== exp_l) begin
                failures++;
                $display("FAIL rw_wave k=%0d: h=%b l=%b expected h=%b l=%b",
                         i + 1, out_h[0], out_l[0], exp_h, exp_l);
            end
            if (i == 7) begin
                bus_read(ra(0, 8), rd);
                checks++;
                if (rd !== 32'h4) begin
                    failures++;
                    $display("FAIL rw_status_dead: got %h expected 4", rd);
                end
            end
        end
        bus_read(ra(0, 4), rd);
        checks++;
        if (rd !== 32'h2) begin
            failures++;
            $display("FAIL rw_dt_readback: got %h expected 2", rd);
        end
    endtask

    task automatic test_bad_channel();
        logic [31:0] rd;
        bus_write(ra(5, 0), 32'h7);
        bus_write(ra(5, 4), 32'h5);
        bus_write(32'h4000_3204, 32'h9);
        bus_write(ra(1, 4), 32'hABCD_0103);
        bus_read(ra(5, 0), rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL ch5_ctrl: got %h expected 0", rd); end
        bus_read(ra(5, 4), rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL ch5_dt: got %h expected 0", rd); end
        bus_read(ra(0, 0), rd);
        checks++;
        if (rd !== 32'h1) begin failures++; $display("FAIL ch0_ctrl_kept: got %h expected 1", rd); end
        bus_read(ra(0, 4), rd);
        checks++;
        if (rd !== 32'h2) begin failures++; $display("FAIL ch0_dt_kept: got %h expected 2", rd); end
        bus_read(ra(1, 4), rd);
        checks++;
        if (rd !== 32'h3) begin failures++; $display("FAIL ch1_dt_trunc: got %h expected 3", rd); end
        bus_read(32'h4000_3204, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL other_page: got %h expected 0", rd); end
        mem_addr = ra(0, 0);
        mem_re   = 1'b0;
        #1;
        checks++;
        if (mem_rdata !== 32'h0) begin
            failures++;
            $display("FAIL no_re: got %h expected 0", mem_rdata);
        end
        mem_addr = '0;
        step();
        checks++;
        if (out_h[0] !== 1'b1 || out_h[1] !== 1'b0) begin
            failures++;
            $display("FAIL bad_ch_outs: out_h=%b expected 01", out_h);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_h !== 2'b00 || out_l !== 2'b00) begin
            failures++;
            $display("FAIL midreset_outs: out_h=%b out_l=%b expected 00/00", out_h, out_l);
        end
        bus_read(ra(0, 0), rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL midreset_ctrl: got %h expected 0", rd); end
        bus_read(ra(0, 8), rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL midreset_status: got %h expected 0", rd); end
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        rst_n     = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        pwm_in    = 2'b00;
        pwm_ena   = 2'b00;
        test_reset();
        test_deadtime();
        test_dt0();
        test_glitch();
        test_disable();
        test_dt_rewrite();
        test_bad_channel();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
